// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: two per-port
// FIFOs drained round-robin into a registered RF write, plus an in-flight busy mask.

module rf_wb_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [4:0]   i_addr,
    input  logic [N-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [4:0]   o_head_addr,
    output logic [N-1:0] o_head_data,
    output logic [31:0]  o_busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]    r_addr [DEPTH];
    logic [N-1:0]  r_data [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // A slot is live when its distance from the read pointer is below the occupancy.
    function automatic logic slot_live(input logic [PW-1:0] slot,
                                       input logic [PW-1:0] rp,
                                       input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = slot - rp;
        return ({1'b0, off} < cnt);
    endfunction

    assign o_full      = (r_cnt == CW'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign o_head_addr = r_addr[r_rp];
    assign o_head_data = r_data[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wp] <= i_addr;
            r_data[r_wp] <= i_data;
        end
    end

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(PW'(i), r_rp, r_cnt)) o_busy[r_addr[i]] = 1'b1;
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [4:0]   a_addr,
    input  logic [N-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [4:0]   b_addr,
    input  logic [N-1:0] b_data,
    output logic         rf_we,
    output logic [4:0]   rf_wr,
    output logic [N-1:0] rf_wd,
    output logic [31:0]  busy_mask,
    output logic         idle
);
    logic         w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic [4:0]   w_a_head_addr, w_b_head_addr;
    logic [N-1:0] w_a_head_data, w_b_head_data;
    logic [31:0]  w_a_busy, w_b_busy, w_busy;
    logic         w_push_a, w_push_b, w_pop_a, w_pop_b;

    logic         r_prefer_b;
    logic         r_vld_p1;
    logic [4:0]   r_wr_p1;
    logic [N-1:0] r_wd_p1;

    // Writes to x0 complete the handshake but are dropped before the FIFO.
    assign a_ready  = !w_a_full;
    assign b_ready  = !w_b_full;
    assign w_push_a = a_valid && !w_a_full && (a_addr != 5'd0);
    assign w_push_b = b_valid && !w_b_full && (b_addr != 5'd0);

    assign w_pop_a = !w_a_empty && (w_b_empty || !r_prefer_b);
    assign w_pop_b = !w_b_empty && (w_a_empty || r_prefer_b);

    rf_wb_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst),
        .i_push(w_push_a), .i_addr(a_addr), .i_data(a_data), .i_pop(w_pop_a),
        .o_full(w_a_full), .o_empty(w_a_empty),
        .o_head_addr(w_a_head_addr), .o_head_data(w_a_head_data), .o_busy(w_a_busy)
    );

    rf_wb_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst),
        .i_push(w_push_b), .i_addr(b_addr), .i_data(b_data), .i_pop(w_pop_b),
        .o_full(w_b_full), .o_empty(w_b_empty),
        .o_head_addr(w_b_head_addr), .o_head_data(w_b_head_data), .o_busy(w_b_busy)
    );

    // Stage p1: granted FIFO head -> registered RF write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prefer_b <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_wr_p1    <= '0;
            r_wd_p1    <= '0;
        end else begin
            r_vld_p1 <= w_pop_a || w_pop_b;
            if (w_pop_a) begin
                r_prefer_b <= 1'b1;
                r_wr_p1    <= w_a_head_addr;
                r_wd_p1    <= w_a_head_data;
            end else if (w_pop_b) begin
                r_prefer_b <= 1'b0;
                r_wr_p1    <= w_b_head_addr;
                r_wd_p1    <= w_b_head_data;
            end
        end
    end

    always_comb begin
        w_busy = w_a_busy | w_b_busy;
        if (r_vld_p1) w_busy[r_wr_p1] = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign rf_we     = r_vld_p1;
    assign rf_wr     = r_wr_p1;
    assign rf_wd     = r_wd_p1;
    assign busy_mask = w_busy;
    assign idle      = w_a_empty && w_b_empty && !r_vld_p1;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.

module tb_rf_wb_arbiter;
    localparam int N     = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]   addr;
        logic [N-1:0] data;
    } req_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, a_ready, b_ready;
    logic [4:0]   a_addr, b_addr;
    logic [N-1:0] a_data, b_data;
    logic         rf_we;
    logic [4:0]   rf_wr;
    logic [N-1:0] rf_wd;
    logic [31:0]  busy_mask;
    logic         idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    req_t src_a[$], src_b[$];
    req_t qa[$], qb[$];
    req_t log_q[$];
    int   log_t[$];
    logic         exp_we;
    logic [4:0]   exp_wr;
    logic [N-1:0] exp_wd;
    bit   last_a;
    int   pct_a, pct_b;
    bit   a_lo_seen, b_lo_seen;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .busy_mask(busy_mask), .idle(idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i].addr] = 1'b1;
        foreach (qb[i]) m[qb[i].addr] = 1'b1;
        if (exp_we) m[exp_wr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic req_t mk(input logic [4:0] ad, input logic [N-1:0] d);
        req_t r;
        r.addr = ad;
        r.data = d;
        return r;
    endfunction

    // One clock: producers present, model decides grant/acceptance, DUT is compared after the edge.
    task automatic tick();
        bit   acc_a, acc_b, grant_a, grant_b;
        req_t e;
        if (!a_valid && src_a.size() > 0 && $urandom_range(99) < pct_a) begin
            a_valid = 1'b1; a_addr = src_a[0].addr; a_data = src_a[0].data;
        end
        if (!b_valid && src_b.size() > 0 && $urandom_range(99) < pct_b) begin
            b_valid = 1'b1; b_addr = src_b[0].addr; b_data = src_b[0].data;
        end
        chk("a_ready", 32'(a_ready), 32'(qa.size() < DEPTH));
        chk("b_ready", 32'(b_ready), 32'(qb.size() < DEPTH));
        if (a_ready !== 1'b1) a_lo_seen = 1'b1;
        if (b_ready !== 1'b1) b_lo_seen = 1'b1;

        acc_a   = a_valid && (qa.size() < DEPTH);
        acc_b   = b_valid && (qb.size() < DEPTH);
        // Alternate when both wait: the port not granted last goes first.
        grant_a = (qa.size() > 0) && (qb.size() == 0 || !last_a);
        grant_b = (qb.size() > 0) && !grant_a;
        if (grant_a) begin
            e = qa.pop_front(); exp_we = 1'b1; exp_wr = e.addr; exp_wd = e.data; last_a = 1'b1;
        end else if (grant_b) begin
            e = qb.pop_front(); exp_we = 1'b1; exp_wr = e.addr; exp_wd = e.data; last_a = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (acc_a && a_addr != 5'd0) qa.push_back(mk(a_addr, a_data));
        if (acc_b && b_addr != 5'd0) qb.push_back(mk(b_addr, b_data));

        @(posedge clk);
        #1;
        cyc++;
        if (acc_a) begin void'(src_a.pop_front()); a_valid = 1'b0; end
        if (acc_b) begin void'(src_b.pop_front()); b_valid = 1'b0; end

        chk("rf_we", 32'(rf_we), 32'(exp_we));
        chk("rf_wr", 32'(rf_wr), 32'(exp_wr));
        chk("rf_wd", rf_wd, exp_wd);
        chk("busy_mask", busy_mask, model_busy());
        chk("idle", 32'(idle), 32'(qa.size() == 0 && qb.size() == 0 && !exp_we));
        if (rf_we === 1'b1) begin
            log_q.push_back(mk(rf_wr, rf_wd));
            log_t.push_back(cyc);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((src_a.size() > 0 || src_b.size() > 0 || qa.size() > 0 || qb.size() > 0 || exp_we)
               && n < budget) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(idle), 32'd1);
    endtask

    task automatic clear_logs();
        log_q.delete(); log_t.delete();
        a_lo_seen = 1'b0; b_lo_seen = 1'b0;
    endtask

    initial begin
        int exp_addr[6];
        int nb, kb, nz;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        exp_we = 1'b0; exp_wr = '0; exp_wd = '0; last_a = 1'b0;
        pct_a = 100; pct_b = 100;
        clear_logs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_wr", 32'(rf_wr), 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_b_ready", 32'(b_ready), 1);
        rst = 1'b0;

        // Contention from reset: A preferred first, then strict alternation
        exp_addr = '{1, 9, 2, 10, 3, 11};
        for (int i = 1; i <= 3; i++) begin
            src_a.push_back(mk(5'(i), 32'hA000_0000 + i));
            src_b.push_back(mk(5'(i + 8), 32'hB000_0000 + i));
        end
        run_until_idle(40);
        chk("cont_count", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < log_q.size()) chk("cont_order", 32'(log_q[i].addr), exp_addr[i]);
        if (log_t.size() == 6) chk("cont_back_to_back", log_t[5] - log_t[0], 5);

        // Single write
        clear_logs();
        src_a.push_back(mk(5'd5, 32'hDEAD_BEEF));
        tick();
        chk("sw_busy_acc", busy_mask, 32'h20);
        chk("sw_we_early", 32'(rf_we), 0);
        tick();
        chk("sw_we", 32'(rf_we), 1);
        chk("sw_wr", 32'(rf_wr), 5);
        chk("sw_wd", rf_wd, 32'hDEAD_BEEF);
        chk("sw_busy_write", busy_mask, 32'h20);
        tick();
        chk("sw_busy_clear", busy_mask, 0);
        chk("sw_idle", 32'(idle), 1);
        chk("sw_hold_wd", rf_wd, 32'hDEAD_BEEF);

        // x0 discard
        clear_logs();
        src_a.push_back(mk(5'd0, 32'hFFFF_FFFF));
        run_until_idle(10);
        repeat (2) tick();
        chk("x0_no_write", log_q.size(), 0);
        chk("x0_ready", 32'(a_lo_seen), 0);
        chk("x0_busy", busy_mask, 0);

        // Backpressure on B while A stays saturated
        clear_logs();
        for (int i = 0; i < 8; i++) src_a.push_back(mk(5'(12 + i), 32'hA100_0000 + i));
        for (int i = 0; i < 6; i++) src_b.push_back(mk(5'(24 + i), 32'hB100_0000 + i));
        run_until_idle(100);
        chk("bp_b_blocked", 32'(b_lo_seen), 1);
        nb = 0; kb = 0;
        foreach (log_q[i]) begin
            if (log_q[i].data[31:24] == 8'hB1) begin
                chk("bp_b_order", log_q[i].data, 32'hB100_0000 + kb);
                kb++;
                nb++;
            end
        end
        chk("bp_b_count", nb, 6);
        chk("bp_total", log_q.size(), 14);

        // Steady single-port stream: push and pop on the same edge
        clear_logs();
        for (int i = 0; i < 8; i++) src_a.push_back(mk(5'(1 + i), 32'h5500_0000 + i));
        run_until_idle(40);
        chk("stream_ready", 32'(a_lo_seen), 0);
        chk("stream_count", log_q.size(), 8);
        if (log_t.size() == 8) chk("stream_rate", log_t[7] - log_t[0], 7);

        // Reset mid-flight before any commit
        clear_logs();
        src_a.push_back(mk(5'd3, 32'h1)); src_a.push_back(mk(5'd4, 32'h2));
        src_b.push_back(mk(5'd6, 32'h3)); src_b.push_back(mk(5'd7, 32'h4));
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(rf_we), 0);
        chk("mid_rst_wr", 32'(rf_wr), 0);
        chk("mid_rst_wd", rf_wd, 0);
        chk("mid_rst_busy", busy_mask, 0);
        chk("mid_rst_idle", 32'(idle), 1);
        a_valid = 1'b0; b_valid = 1'b0;
        src_a.delete(); src_b.delete(); qa.delete(); qb.delete();
        exp_we = 1'b0; exp_wr = '0; exp_wd = '0; last_a = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete(); log_t.delete();
        repeat (4) tick();
        chk("mid_rst_no_write", log_q.size(), 0);

        // Randomized traffic
        clear_logs();
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            src_a.push_back(mk(5'($urandom_range(31)), $urandom));
            src_b.push_back(mk(5'($urandom_range(31)), $urandom));
            if (src_a[i].addr != 0) nz++;
            if (src_b[i].addr != 0) nz++;
        end
        pct_a = 30 + $urandom_range(70);
        pct_b = 30 + $urandom_range(70);
        run_until_idle(2000);
        chk("rand_count", log_q.size(), nz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Writeback arbiter for the 32-entry register file's single write port. Two producers (port A: ALU writeback, port B: load/long-latency writeback) each present valid/ready write requests. Each port has its own small FIFO. A round-robin arbiter drains one write per cycle into registered RF write signals (rf_we/rf_wr/rf_wd). A busy_mask tells issue logic which registers have writes still in flight.

Parameters:
N, 32, data width; must match the register file data width.
DEPTH, 2, entries per port FIFO; a power of 2, at least 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
a_valid  input  1  port A request valid.
a_ready  output  1  port A can accept a request.
a_addr  input  5  port A destination register.
a_data  input  N  port A write data.
b_valid  input  1  port B request valid.
b_ready  output  1  port B can accept a request.
b_addr  input  5  port B destination register.
b_data  input  N  port B write data.
rf_we  output  1  register file write enable (registered).
rf_wr  output  5  register file write address (registered).
rf_wd  output  N  register file write data (registered).
busy_mask  output  32  bit r set while a write to register r is pending.
idle  output  1  no pending writes anywhere in the block.

Behaviour:
- Reset:
  - rst=1 clears both FIFOs and the output register immediately (asynchronously).
  - rf_we=0, rf_wr=0, rf_wd=0, busy_mask=0, idle=1.
  - Arbiter pointer is set to prefer A.
  - Reset mid-operation discards all buffered writes; none reach the RF.
- Handshake:
  - A transfer on port X occurs at a posedge where x_valid=1 and x_ready=1.
  - x_ready = !fifo_x_full and is independent of x_valid.
  - A full FIFO never accepts, even if it pops on the same edge (no pass-through).
  - A producer holds valid/addr/data stable until the transfer.
- Register 0 writes:
  - A transfer with addr=0 completes normally but is discarded.
  - It is not enqueued, never drives rf_we, and never sets busy_mask.
- Enqueue/dequeue:
  - Each port is an independent FIFO with in-order drain.
  - An entry enqueued at edge E is first eligible for pop at edge E+1.
  - Push and pop on the same edge of a non-full FIFO are both performed; occupancy is unchanged.
- Arbitration, evaluated each posedge:
  - Only A non-empty: pop A. Only B non-empty: pop B.
  - Both non-empty: pop the port indicated by the pointer, then the pointer flips to the other port.
  - A single-port pop also sets the pointer to the other port.
  - The popped entry loads the output register: rf_we=1, rf_wr=addr, rf_wd=data.
  - If nothing is popped: rf_we=0, and rf_wr/rf_wd hold their values.
  - Throughput: one RF write per cycle.
- Latency:
  - Transfer at edge E → rf_we=1 during cycle E+1..E+2 (best case, no contention).
  - The RF commits the write at edge E+2.
  - Under contention, the worst-case wait per entry is bounded by the round-robin (alternating).
- busy_mask:
  - Bit r = OR over valid entries in FIFO A, FIFO B, and the output register (while rf_we=1) whose addr==r.
  - Combinational from state; clears the cycle after the RF commit edge.
  - busy_mask[0] is always 0.
- idle = both FIFOs empty and rf_we=0.
- Ordering:
  - Same-port writes commit in acceptance order.
  - Cross-port order follows grant order.
  - Issue logic uses busy_mask to avoid two in-flight writes to one register from different ports; the block does not reorder or merge.

Test Plan:
- Single write: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one accepted edge → rf_we=1, rf_wr=5, rf_wd=0xDEADBEEF exactly one cycle later; busy_mask=0x20 from acceptance until the cycle after commit; idle returns to 1.
- Contention: both ports push continuously (A: addr 1,2,3; B: addr 9,10,11) from reset → RF write sequence is 1,9,2,10,3,11, with rf_we high for 6 consecutive cycles.
- Backpressure: hold b_valid=1 while stalling drain by keeping port A saturated → b_ready drops after DEPTH=2 accepts; no lost or duplicated B writes; all commit in order.
- x0 discard: a_addr=0, a_data=0xFFFFFFFF accepted → a_ready stays 1, rf_we never asserts, busy_mask[0]=0, idle stays 1.
- Reset mid-flight: fill both FIFOs with 4 writes, assert rst for one cycle before any commit → outputs go to 0 immediately, busy_mask=0, idle=1, and no rf_we pulse after release.
- Simultaneous push/pop: steady single-port stream, a_valid=1 every cycle → a_ready stays 1, one commit per cycle, FIFO occupancy never exceeds 1.
